// File: rtl/reg_scoreboard.sv
// Issue-stage register scoreboard: per-register pending-write counters,
// RAW/WAW stall generation into pc, and a pipeline drain sequence.
module reg_scoreboard #(
    parameter int NREGS     = 32,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic [$clog2(NREGS)-1:0] issue_rs,
    input  logic                     issue_rs_en,
    input  logic [$clog2(NREGS)-1:0] issue_rt,
    input  logic                     issue_rt_en,
    input  logic [$clog2(NREGS)-1:0] issue_rd,
    input  logic                     issue_rd_en,
    input  logic                     wb_valid,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic                     drain_req,
    output logic                     stall_en,
    output logic                     issue_fire,
    output logic [NREGS-1:0]         busy_mask,
    output logic                     drain_done,
    output logic                     sb_err
);

    localparam int IW = $clog2(NREGS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt     [NREGS];
    logic [CNT_W-1:0] cnt_nxt [NREGS];
    logic [NREGS-1:0] inc_vec, dec_vec, busy_nxt;
    logic             raw_rs, raw_rt, waw, hazard, err_set;

    // A source whose only pending write retires this cycle is not a hazard.
    always_comb begin
        raw_rs = issue_rs_en && (cnt[issue_rs] != '0);
        raw_rt = issue_rt_en && (cnt[issue_rt] != '0);
        if (WB_BYPASS != 0) begin
            if (wb_valid && wb_rd == issue_rs && cnt[issue_rs] == CNT_ONE)
                raw_rs = 1'b0;
            if (wb_valid && wb_rd == issue_rt && cnt[issue_rt] == CNT_ONE)
                raw_rt = 1'b0;
        end
        waw    = issue_rd_en && (cnt[issue_rd] == CNT_MAX);
        hazard = raw_rs || raw_rt || waw;
    end

    assign stall_en   = !rst && (state == RUN) && !(issue_valid && hazard);
    assign issue_fire = issue_valid && stall_en;
    assign drain_done = (state == DONE);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NREGS; i++) begin
            inc_vec[i] = issue_fire && issue_rd_en && (issue_rd == IW'(i));
            dec_vec[i] = wb_valid && (wb_rd == IW'(i));
        end
    end

    // Writeback to an idle register is dropped and flagged.
    always_comb begin
        cnt_nxt  = cnt;
        busy_nxt = '0;
        err_set  = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (dec_vec[i] && cnt[i] == '0)
                err_set = 1'b1;
            if (inc_vec[i] && !dec_vec[i])
                cnt_nxt[i] = cnt[i] + CNT_ONE;
            else if (dec_vec[i] && !inc_vec[i] && cnt[i] != '0)
                cnt_nxt[i] = cnt[i] - CNT_ONE;
            busy_nxt[i] = |cnt_nxt[i];
        end
    end

    // DRAIN looks at post-update counts so the final writeback ends it.
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (drain_req) state_nxt = DRAIN;
            DRAIN: begin
                if (!drain_req)
                    state_nxt = RUN;
                else if (busy_nxt == '0)
                    state_nxt = DONE;
            end
            DONE:    if (!drain_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            busy_mask <= '0;
            sb_err    <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                cnt[i] <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            busy_mask <= busy_nxt;
            if (err_set)
                sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, saturation, drain, error.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs, issue_rt, issue_rd, wb_rd;
    logic        issue_rs_en, issue_rt_en, issue_rd_en;
    logic        wb_valid, drain_req;
    logic        stall_en, issue_fire, drain_done, sb_err;
    logic [31:0] busy_mask;

    int n_chk  = 0;
    int n_fail = 0;

    reg_scoreboard #(.NREGS(32), .CNT_W(2), .WB_BYPASS(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rs    (issue_rs),
        .issue_rs_en (issue_rs_en),
        .issue_rt    (issue_rt),
        .issue_rt_en (issue_rt_en),
        .issue_rd    (issue_rd),
        .issue_rd_en (issue_rd_en),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .drain_req   (drain_req),
        .stall_en    (stall_en),
        .issue_fire  (issue_fire),
        .busy_mask   (busy_mask),
        .drain_done  (drain_done),
        .sb_err      (sb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge, settle, then check.
    task automatic cyc(input logic iv,
                       input logic [4:0] rs, input logic rse,
                       input logic [4:0] rt, input logic rte,
                       input logic [4:0] rd, input logic rde,
                       input logic wv, input logic [4:0] wr,
                       input logic dr);
        @(negedge clk);
        issue_valid = iv;
        issue_rs    = rs;
        issue_rs_en = rse;
        issue_rt    = rt;
        issue_rt_en = rte;
        issue_rd    = rd;
        issue_rd_en = rde;
        wb_valid    = wv;
        wb_rd       = wr;
        drain_req   = dr;
        #1;
    endtask

    task automatic idle(input logic dr);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, dr);
    endtask

    task automatic iss_rd(input logic [4:0] rd);
        cyc(1, 0, 0, 0, 0, rd, 1, 0, 0, 0);
    endtask

    task automatic iss_rs(input logic [4:0] rs, input logic wv);
        cyc(1, rs, 1, 0, 0, 0, 0, wv, rs, 0);
    endtask

    task automatic wb(input logic [4:0] r, input logic dr);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, r, dr);
    endtask

    initial begin
        rst = 1'b1;
        cyc(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
        chk("rst_stall", stall_en, 0);
        chk("rst_fire", issue_fire, 0);
        idle(0);
        chk("rst_busy", busy_mask, 32'h0);
        chk("rst_done", drain_done, 0);
        chk("rst_err", sb_err, 0);
        rst = 1'b0;

        // no-hazard stream
        iss_rd(5);
        chk("nh_fire_rd5", issue_fire, 1);
        cyc(1, 6, 1, 7, 1, 0, 0, 0, 0, 0);
        chk("nh_stall_rs6rt7", stall_en, 1);
        chk("nh_busy", busy_mask, 32'h20);
        idle(0);
        chk("nh_busy_hold", busy_mask, 32'h20);

        // RAW on r5, released by bypassed writeback
        iss_rs(5, 0);
        chk("raw_stall0", stall_en, 0);
        chk("raw_fire0", issue_fire, 0);
        iss_rs(5, 0);
        chk("raw_stall1", stall_en, 0);
        iss_rs(5, 1);
        chk("raw_bypass_stall", stall_en, 1);
        chk("raw_bypass_fire", issue_fire, 1);
        idle(0);
        chk("raw_busy_clr", busy_mask, 32'h0);

        // WAW saturation on r3
        iss_rd(3);
        chk("waw_fire1", issue_fire, 1);
        iss_rd(3);
        chk("waw_fire2", issue_fire, 1);
        iss_rd(3);
        chk("waw_fire3", issue_fire, 1);
        iss_rd(3);
        chk("waw_stall4", stall_en, 0);
        chk("waw_busy", busy_mask, 32'h08);
        cyc(1, 0, 0, 0, 0, 3, 1, 1, 3, 0);
        chk("waw_no_bypass", stall_en, 0);
        iss_rd(3);
        chk("waw_fire4", issue_fire, 1);
        iss_rd(3);
        chk("waw_resat", stall_en, 0);
        wb(3, 0);
        wb(3, 0);
        wb(3, 0);
        chk("waw_cnt1_busy", busy_mask, 32'h08);
        idle(0);
        chk("waw_cnt0_busy", busy_mask, 32'h0);

        // simultaneous issue and writeback on r4
        iss_rd(4);
        cyc(1, 0, 0, 0, 0, 4, 1, 1, 4, 0);
        chk("sim_fire", issue_fire, 1);
        wb(4, 0);
        chk("sim_busy", busy_mask, 32'h10);
        idle(0);
        chk("sim_busy_clr", busy_mask, 32'h0);
        chk("sim_no_err", sb_err, 0);

        // drain with two pending writes
        iss_rd(1);
        iss_rd(2);
        idle(1);
        cyc(1, 9, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("dr_stall", stall_en, 0);
        chk("dr_fire", issue_fire, 0);
        chk("dr_done0", drain_done, 0);
        wb(1, 1);
        chk("dr_done1", drain_done, 0);
        wb(2, 1);
        chk("dr_done2", drain_done, 0);
        cyc(1, 9, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("dr_done_rise", drain_done, 1);
        chk("dr_done_stall", stall_en, 0);
        cyc(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("dr_drop_done", drain_done, 1);
        chk("dr_drop_stall", stall_en, 0);
        cyc(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("dr_run_stall", stall_en, 1);
        chk("dr_run_done", drain_done, 0);

        // drain with nothing pending
        idle(1);
        chk("dz_c0", drain_done, 0);
        idle(1);
        chk("dz_c1", drain_done, 0);
        idle(1);
        chk("dz_c2", drain_done, 1);
        idle(0);
        idle(0);
        chk("dz_run", stall_en, 1);

        // drain aborted while in DRAIN
        iss_rd(1);
        idle(1);
        cyc(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("da_drain_stall", stall_en, 0);
        cyc(1, 9, 1, 0, 0, 0, 0, 1, 1, 0);
        chk("da_run_stall", stall_en, 1);
        idle(0);
        chk("da_busy", busy_mask, 32'h0);

        // spurious writeback sets the sticky error; reset clears it
        wb(9, 0);
        idle(0);
        chk("err_set", sb_err, 1);
        iss_rd(12);
        idle(0);
        chk("err_sticky", sb_err, 1);
        chk("err_busy", busy_mask, 32'h1000);
        rst = 1'b1;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst2_stall", stall_en, 0);
        chk("rst2_fire", issue_fire, 0);
        idle(0);
        rst = 1'b0;
        iss_rs(12, 0);
        chk("rst2_err", sb_err, 0);
        chk("rst2_busy", busy_mask, 32'h0);
        chk("rst2_run", stall_en, 1);
        chk("rst2_fire_ok", issue_fire, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-stage hazard controller for the pipelined core.
- Tracks in-flight writes to each architectural register and drives stall_en into pc.
- Holds fetch/decode when a decoded instruction reads or overwrites a register whose write has not yet retired to the register file.
- Provides a drain sequence that empties the pipeline before a halt or mode change.

Parameters:
- NREGS, 32, number of architectural registers; register index width is clog2(NREGS).
- CNT_W, 2, width of the per-register pending-write counter.
- WB_BYPASS, 1, 1 means a same-cycle writeback to the last pending write clears the hazard for the issuing instruction.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  decode stage presents an instruction.
- issue_rs  in  5  source register A index.
- issue_rs_en  in  1  source A is read.
- issue_rt  in  5  source register B index.
- issue_rt_en  in  1  source B is read.
- issue_rd  in  5  destination register index.
- issue_rd_en  in  1  instruction writes rd.
- wb_valid  in  1  writeback stage commits a write this cycle.
- wb_rd  in  5  register written by writeback.
- drain_req  in  1  request to empty the pipeline; level-sensitive.
- stall_en  out  1  1 = pipeline advances; 0 = pc/decode hold.
- issue_fire  out  1  instruction accepted this cycle.
- busy_mask  out  NREGS  bit i set when pending count of reg i is non-zero (registered).
- drain_done  out  1  pipeline empty in DRAIN state.
- sb_err  out  1  sticky error flag.

Behaviour:
- Reset: all counters 0, state RUN, busy_mask 0, drain_done 0, sb_err 0. During rst, stall_en = 0 and issue_fire = 0.
- Hazard terms (combinational, from registered counters cnt[]):
  - RAW: issue_rs_en and cnt[rs] != 0, or issue_rt_en and cnt[rt] != 0.
  - WAW-overflow: issue_rd_en and cnt[rd] == 2^CNT_W-1.
- WB_BYPASS=1: a RAW term is suppressed when wb_valid, wb_rd equals the source index, and that source's cnt == 1. WAW-overflow is never bypassed.
- stall_en = (state==RUN) and not(issue_valid and hazard).
- issue_fire = issue_valid and stall_en.
- Counter update at posedge, per register i:
  - inc when issue_fire and issue_rd_en and rd==i.
  - dec when wb_valid and wb_rd==i.
  - inc and dec together leave the counter unchanged.
  - dec with cnt==0 is ignored and sets sb_err (sticky until rst).
  - Counter never wraps; overflow is prevented by the WAW stall.
- busy_mask reflects the counters after the update, one cycle after fire/wb.
- FSM states:
  - RUN: drain_req goes to DRAIN.
  - DRAIN: stall_en=0; writebacks still retire. When all counters are 0, go to DONE.
  - DONE: drain_done=1, stall_en=0. Deassert of drain_req returns to RUN next cycle with drain_done=0.
  - drain_req dropped while in DRAIN returns to RUN immediately.
- drain_req with all counters already zero: DRAIN for one cycle, then DONE. drain_done is first high 2 cycles after drain_req.
- rst mid-DRAIN or DONE: return to RUN, counters cleared. In-flight writebacks arriving after rst hit zero counters and set sb_err. The bench must avoid this or expect the flag.
- Register 0 gets no special treatment; it is tracked like any other register.
- Latency: stall_en is combinational from inputs (same cycle); the counter/busy_mask effect is 1 cycle.

Test Plan:
- No-hazard stream: issue rd=5, then rs=6/rt=7 reads with no wb → stall_en stays 1, busy_mask=0x20 one cycle later.
- RAW:
  - Issue rd=5, next cycle issue rs=5 → stall_en=0 until wb_valid with wb_rd=5.
  - With WB_BYPASS=1, stall_en=1 in the wb cycle; with WB_BYPASS=0, stall_en=1 the cycle after.
- WAW saturation (CNT_W=2): three issues to rd=3 fire; fourth stalls; one wb to 3 → fourth fires next cycle, cnt[3] stays 3.
- Simultaneous: issue_fire to rd=4 while wb_rd=4 with cnt[4]=1 → cnt[4] stays 1, busy_mask bit 4 stays set.
- Drain:
  - Two pending writes (regs 1,2), assert drain_req → stall_en=0 at once; drain_done rises the cycle after the last wb.
  - Drop drain_req → stall_en=1 next cycle.
- Error/reset: wb_valid to reg 9 with cnt 0 → sb_err=1 and stays 1; assert rst → sb_err=0, busy_mask=0, state RUN.
